ps2_keyboard_controller: RTL and testbench
==========================================

# ps2_keyboard_controller

Sequences the PS/2 byte receiver and turns its byte stream into Pong paddle controls. It holds the receiver in wait mode and consumes each received byte. It decodes the 0xE0 (extended) and 0xF0 (break) prefixes into complete key events, and keeps held-key levels for the four paddle keys. It sits between the PS/2 receiver and the game-logic paddle movers.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: clk cycles allowed between a prefix byte and its completing byte (20 ms at 50 MHz).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: controller active; low idles the receiver and clears all key state.
- `rx_ready` in 1: one-cycle pulse from the receiver; `rx_data` is valid in the same cycle.
- `rx_data` in 8: received byte.
- `rx_wait` out 1: drives the receiver's wait-mode input.
- `key_event` out 1: one-cycle pulse; a complete make or break code was decoded.
- `key_code` out 8: final (non-prefix) byte of the last event.
- `key_ext` out 1: last event carried the 0xE0 prefix.
- `key_break` out 1: last event was a break (release) code.
- `paddle_l_up` out 1: level; W (0x1D) held.
- `paddle_l_dn` out 1: level; S (0x1B) held.
- `paddle_r_up` out 1: level; extended 0x75 (up arrow) held.
- `paddle_r_dn` out 1: level; extended 0x72 (down arrow) held.
- `timeout_err` out 1: one-cycle pulse; a pending prefix was discarded.
- `overflow_err` out 1: one-cycle pulse; the keyboard sent 0x00 or 0xFF.

## Operation
- **Decode FSM.** Four states: `BASE`, `EXT`, `BRK`, `EXT_BRK`. The state encodes an ext flag and a brk flag.
- **Prefix bytes.** 0xE0 sets ext; 0xF0 sets brk. Either prefix may repeat. Order does not matter: F0 followed by E0 also reaches `EXT_BRK`.
- **Completing byte.** Any other byte, except the special bytes below, completes a code:
  - pulse `key_event`;
  - latch `key_code`, `key_ext` = ext flag, `key_break` = brk flag;
  - return to `BASE`.
- **Paddle levels.** Matching is exact on (ext, code):
  - a make code sets the matching paddle level;
  - a break code clears it;
  - typematic repeats re-pulse `key_event` and leave levels unchanged.
- **Special bytes 0xAA, 0xFA, 0xEE, 0xFE.** Consumed silently; flags cleared; no event.
- **Special bytes 0x00, 0xFF.** Clear all paddle levels and flags; pulse `overflow_err`; no event.
- **Prefix timeout.** A counter runs while the state is not `BASE` and clears on every accepted `rx_ready`. On reaching `TIMEOUT_CYCLES-1`: return to `BASE`, pulse `timeout_err`, levels unchanged.
- **`rx_wait`.** Equals `enable` (registered).
- **`enable` low:**
  - `rx_wait` = 0, state = `BASE`, counter cleared, paddle levels cleared;
  - `rx_ready` is ignored;
  - `key_code`, `key_ext` and `key_break` hold their values.

## Timing
- **Reset values.** All outputs 0; state `BASE`; counter 0.
- **Latency.** `rx_ready` in cycle N → `key_event`, `key_*` and paddle levels updated in cycle N+1.
- **`rx_wait` latency.** Follows `enable` with 1 cycle of latency.
- **Timeout vs. byte.** If `rx_ready` arrives in the same cycle the counter expires, the byte wins: it is processed in the current state, the counter clears, and there is no `timeout_err`.
- **`enable` vs. byte.** If `enable` falls in the same cycle as `rx_ready`, the byte is dropped.
- **Reset mid-sequence.** A pending prefix is lost; there is no event and no error pulse.
- **Error pulses.** Each error pulse lasts exactly 1 cycle.

## Configuration
- **`PS2_KBD_PAUSE_EN` defined:**
  - adds output `pause_toggle` out 1 (reset 0);
  - it inverts on each non-extended make of Space (0x29);
  - typematic repeats of 0x29 are ignored until a Space break has been seen;
  - `enable` low clears the repeat-suppress flag but not `pause_toggle`.
- **`PS2_KBD_PAUSE_EN` undefined:** the port and its logic are absent. 0x29 still produces normal `key_event`s.

## Structure
- **Package `ps2_kbd_pkg`:**
  - scan-code constants: `PS2_EXT` 0xE0, `PS2_BRK` 0xF0, `PS2_BAT` 0xAA, `PS2_ACK` 0xFA, `PS2_ECHO` 0xEE, `PS2_RESEND` 0xFE, `PS2_ERR0` 0x00, `PS2_ERR1` 0xFF;
  - key constants: `KEY_W`, `KEY_S`, `KEY_UP`, `KEY_DN`, `KEY_SPACE`;
  - the FSM state encoding.
- **Sub-module `ps2_prefix_timer`.** Holds the timeout counter, with width `$clog2(TIMEOUT_CYCLES)`.
  - Inputs: `run`, `clear`.
  - Output: `expire` pulse.

## Test plan
- Bytes 0x1D, then 0xF0 0x1D → `paddle_l_up` 1 after the first byte, 0 after the second. Two `key_event`s; the second has `key_break`=1, `key_code`=0x1D.
- Bytes 0xE0 0x75, then 0xE0 0xF0 0x75 → `paddle_r_up` set then cleared; `key_ext`=1 on both events; `paddle_l_up` stays 0.
- Byte 0xE0, then idle `TIMEOUT_CYCLES` cycles, then 0x1D → one `timeout_err` pulse; the event has `key_ext`=0 and `paddle_l_up`=1.
- Hold 0x1B and 0x72 (ext), then send 0xFF → `overflow_err` pulse and all paddle levels 0. Then 0xFA → no event.
- `rx_ready` for 0x1B in the expiry cycle of a pending 0xF0 → break of S decoded, no `timeout_err`. Then `enable`=0 → `rx_wait`=0 next cycle and levels cleared.
- With `PS2_KBD_PAUSE_EN` defined: 0x29, 0x29, 0xF0 0x29, 0x29 → `pause_toggle` goes 1, stays 1, then goes 0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - PS/2 scan-code constants, decode states and paddle key matching
package ps2_kbd_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   localparam logic [7:0] KEY_W      = 8'h1D;
   localparam logic [7:0] KEY_S      = 8'h1B;
   localparam logic [7:0] KEY_UP     = 8'h75;
   localparam logic [7:0] KEY_DN     = 8'h72;
   localparam logic [7:0] KEY_SPACE  = 8'h29;

   // bit 1 = break flag, bit 0 = extended flag
   typedef enum logic [1:0] {
      BASE    = 2'b00,
      EXT     = 2'b01,
      BRK     = 2'b10,
      EXT_BRK = 2'b11
   } ps2_state_t;

   // One-hot paddle slot {r_dn, r_up, l_dn, l_up} for an (ext, code) pair
   function automatic logic [3:0] paddle_mask(input logic ext, input logic [7:0] code);
      paddle_mask = 4'b0000;
      if (!ext && code == KEY_W)  paddle_mask = 4'b0001;
      if (!ext && code == KEY_S)  paddle_mask = 4'b0010;
      if (ext && code == KEY_UP)  paddle_mask = 4'b0100;
      if (ext && code == KEY_DN)  paddle_mask = 4'b1000;
   endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// rtl/ps2_prefix_timer.sv - counts idle cycles while a prefix is pending; pulses expire on the last one
module ps2_prefix_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   assign expire = run && (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear || !run || expire)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/ps2_keyboard_controller.sv
// rtl/ps2_keyboard_controller.sv - PS/2 byte stream to key events and Pong paddle levels
// Optional Space pause toggle output when PS2_KBD_PAUSE_EN is defined.
module ps2_keyboard_controller
   import ps2_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       rx_wait,
   output logic       key_event,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       paddle_l_up,
   output logic       paddle_l_dn,
   output logic       paddle_r_up,
   output logic       paddle_r_dn,
   output logic       timeout_err,
   output logic       overflow_err
`ifdef PS2_KBD_PAUSE_EN
   ,
   output logic       pause_toggle
`endif
);

   ps2_state_t state, state_n;
   logic [3:0] paddles, paddles_n, mask;
   logic       event_n, ext_n, brk_n, terr_n, oerr_n;
   logic [7:0] code_n;
   logic       accept, expire, cur_ext, cur_brk;
`ifdef PS2_KBD_PAUSE_EN
   logic       pause_n, space_held, space_held_n;
`endif

   assign accept  = enable && rx_ready;
   assign cur_ext = state[0];
   assign cur_brk = state[1];
   assign mask    = paddle_mask(cur_ext, rx_data);

   assign {paddle_r_dn, paddle_r_up, paddle_l_dn, paddle_l_up} = paddles;

   ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .run    (state != BASE),
      .clear  (accept || !enable),
      .expire (expire)
   );

   always_comb begin
      state_n   = state;
      paddles_n = paddles;
      event_n   = 1'b0;
      code_n    = key_code;
      ext_n     = key_ext;
      brk_n     = key_break;
      terr_n    = 1'b0;
      oerr_n    = 1'b0;
`ifdef PS2_KBD_PAUSE_EN
      pause_n      = pause_toggle;
      space_held_n = space_held;
`endif
      if (!enable) begin
         state_n   = BASE;
         paddles_n = 4'b0000;
`ifdef PS2_KBD_PAUSE_EN
         space_held_n = 1'b0;
`endif
      end else if (accept) begin
         // a byte arriving in the expiry cycle is decoded in the pending state
         case (rx_data)
            PS2_EXT: state_n = ps2_state_t'({cur_brk, 1'b1});
            PS2_BRK: state_n = ps2_state_t'({1'b1, cur_ext});
            PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND: state_n = BASE;
            PS2_ERR0, PS2_ERR1: begin
               state_n   = BASE;
               paddles_n = 4'b0000;
               oerr_n    = 1'b1;
            end
            default: begin
               state_n   = BASE;
               event_n   = 1'b1;
               code_n    = rx_data;
               ext_n     = cur_ext;
               brk_n     = cur_brk;
               paddles_n = cur_brk ? (paddles & ~mask) : (paddles | mask);
`ifdef PS2_KBD_PAUSE_EN
               if (!cur_ext && rx_data == KEY_SPACE) begin
                  if (cur_brk) begin
                     space_held_n = 1'b0;
                  end else if (!space_held) begin
                     pause_n      = !pause_toggle;
                     space_held_n = 1'b1;
                  end
               end
`endif
            end
         endcase
      end else if (expire) begin
         state_n = BASE;
         terr_n  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= BASE;
         paddles      <= 4'b0000;
         rx_wait      <= 1'b0;
         key_event    <= 1'b0;
         key_code     <= 8'h00;
         key_ext      <= 1'b0;
         key_break    <= 1'b0;
         timeout_err  <= 1'b0;
         overflow_err <= 1'b0;
`ifdef PS2_KBD_PAUSE_EN
         pause_toggle <= 1'b0;
         space_held   <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         paddles      <= paddles_n;
         rx_wait      <= enable;
         key_event    <= event_n;
         key_code     <= code_n;
         key_ext      <= ext_n;
         key_break    <= brk_n;
         timeout_err  <= terr_n;
         overflow_err <= oerr_n;
`ifdef PS2_KBD_PAUSE_EN
         pause_toggle <= pause_n;
         space_held   <= space_held_n;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// tb/tb_ps2_keyboard_controller.sv - randomized byte-stream bench against a key-event reference model
module tb_ps2_keyboard_controller;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_wait, key_event, key_ext, key_break;
   logic [7:0] key_code;
   logic       paddle_l_up, paddle_l_dn, paddle_r_up, paddle_r_dn;
   logic       timeout_err, overflow_err;
`ifdef PS2_KBD_PAUSE_EN
   logic       pause_toggle;
`endif

   ps2_keyboard_controller #(.TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_wait      (rx_wait),
      .key_event    (key_event),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_break    (key_break),
      .paddle_l_up  (paddle_l_up),
      .paddle_l_dn  (paddle_l_dn),
      .paddle_r_up  (paddle_r_up),
      .paddle_r_dn  (paddle_r_dn),
      .timeout_err  (timeout_err),
      .overflow_err (overflow_err)
`ifdef PS2_KBD_PAUSE_EN
      ,
      .pause_toggle (pause_toggle)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_tmo_seen = 0;

   // model of the keyboard protocol
   bit         m_ext, m_brk;
   bit         m_held [4];
   logic [7:0] m_code;
   bit         m_kext, m_kbrk;
   int         m_tmo;
   bit         m_pause, m_sp;

   always @(negedge clk) if (timeout_err) n_tmo_seen++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int key_slot(input bit e, input logic [7:0] c);
      if (!e && c == 8'h1D) return 0;
      if (!e && c == 8'h1B) return 1;
      if (e && c == 8'h75) return 2;
      if (e && c == 8'h72) return 3;
      return -1;
   endfunction

   function automatic logic [3:0] exp_paddles();
      return {m_held[3], m_held[2], m_held[1], m_held[0]};
   endfunction

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_code = 8'h00; m_kext = 0; m_kbrk = 0;
      m_pause = 0; m_sp = 0;
      foreach (m_held[i]) m_held[i] = 0;
   endtask

   task automatic check_outputs(input bit ev, input bit oe);
      check_eq("key_event", key_event, ev);
      check_eq("key_code", key_code, m_code);
      check_eq("key_ext", key_ext, m_kext);
      check_eq("key_break", key_break, m_kbrk);
      check_eq("paddles", {paddle_r_dn, paddle_r_up, paddle_l_dn, paddle_l_up}, exp_paddles());
      check_eq("overflow_err", overflow_err, oe);
      check_eq("timeout_count", n_tmo_seen, m_tmo);
      check_eq("rx_wait", rx_wait, 1);
`ifdef PS2_KBD_PAUSE_EN
      check_eq("pause_toggle", pause_toggle, m_pause);
`endif
   endtask

   // idle cycles before the byte; the byte lands idle+1 cycles after the previous one
   task automatic send(input logic [7:0] b, input int idle);
      bit ev, oe;
      int s;
      ev = 0; oe = 0;
      repeat (idle) @(negedge clk);
      if ((m_ext || m_brk) && idle + 1 > T) begin
         m_ext = 0; m_brk = 0; m_tmo++;
      end
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
         m_ext = 0; m_brk = 0;
      end else if (b == 8'h00 || b == 8'hFF) begin
         m_ext = 0; m_brk = 0; oe = 1;
         foreach (m_held[i]) m_held[i] = 0;
      end else begin
         ev = 1; m_code = b; m_kext = m_ext; m_kbrk = m_brk;
         s = key_slot(m_ext, b);
         if (s >= 0) m_held[s] = !m_brk;
         if (!m_ext && b == 8'h29) begin
            if (m_brk) m_sp = 0;
            else if (!m_sp) begin m_pause = !m_pause; m_sp = 1; end
         end
         m_ext = 0; m_brk = 0;
      end
      rx_data = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check_outputs(ev, oe);
   endtask

   task automatic disable_pulse(input bit with_byte);
      enable = 1'b0;
      rx_ready = with_byte;
      rx_data = 8'h1D;
      @(negedge clk);
      rx_ready = 1'b0;
      m_ext = 0; m_brk = 0; m_sp = 0;
      foreach (m_held[i]) m_held[i] = 0;
      check_eq("dis_rx_wait", rx_wait, 0);
      check_eq("dis_event", key_event, 0);
      check_eq("dis_paddles", {paddle_r_dn, paddle_r_up, paddle_l_dn, paddle_l_up}, 4'h0);
      check_eq("dis_code_hold", key_code, m_code);
      enable = 1'b1;
      @(negedge clk);
      check_eq("en_rx_wait", rx_wait, 1);
      check_eq("en_event", key_event, 0);
   endtask

   task automatic flush();
      repeat (T + 2) @(negedge clk);
      if (m_ext || m_brk) begin
         m_ext = 0; m_brk = 0; m_tmo++;
      end
      check_eq("flush_timeouts", n_tmo_seen, m_tmo);
      check_eq("flush_event", key_event, 0);
   endtask

   logic [7:0] pick_tab [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29,
                                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'h5A};

   initial begin
      logic [7:0] b;
      int idle;
      model_reset();
      m_tmo = 0;

      repeat (3) @(negedge clk);
      check_eq("rst_outputs", {rx_wait, key_event, key_code, key_ext, key_break, paddle_l_up,
                               paddle_l_dn, paddle_r_up, paddle_r_dn, timeout_err, overflow_err}, 0);
      reset = 1'b1;
      enable = 1'b1;
      check_eq("rx_wait_pre", rx_wait, 0);
      @(negedge clk);
      check_eq("rx_wait_post", rx_wait, 1);

      // W make then break
      send(8'h1D, 0);
      check_eq("tp1_lup_set", paddle_l_up, 1);
      send(8'hF0, 0); send(8'h1D, 0);
      check_eq("tp1_lup_clr", paddle_l_up, 0);
      check_eq("tp1_brk", key_break, 1);

      // extended up arrow make then break
      send(8'hE0, 0); send(8'h75, 0);
      check_eq("tp2_rup_set", paddle_r_up, 1);
      send(8'hE0, 1); send(8'hF0, 2); send(8'h75, 0);
      check_eq("tp2_rup_clr", paddle_r_up, 0);
      check_eq("tp2_ext", key_ext, 1);
      check_eq("tp2_lup", paddle_l_up, 0);

      // prefix timeout, then a plain byte
      send(8'hE0, 0); send(8'h1D, T);
      check_eq("tp3_tmo", n_tmo_seen, 1);
      check_eq("tp3_ext", key_ext, 0);
      check_eq("tp3_lup", paddle_l_up, 1);

      // overflow clears all levels
      send(8'h1B, 0); send(8'hE0, 0); send(8'h72, 0);
      send(8'hFF, 0);
      check_eq("tp4_oerr", overflow_err, 1);
      check_eq("tp4_levels", {paddle_r_dn, paddle_r_up, paddle_l_dn, paddle_l_up}, 4'h0);
      send(8'hFA, 0);
      check_eq("tp4_no_event", key_event, 0);

      // byte in the expiry cycle wins over the timeout
      send(8'h1B, 0); send(8'h1D, 0);
      send(8'hF0, 0); send(8'h1B, T - 1);
      check_eq("tp5_code", key_code, 8'h1B);
      check_eq("tp5_brk", key_break, 1);
      check_eq("tp5_tmo", n_tmo_seen, 1);
      disable_pulse(0);
      disable_pulse(1);

      // reset with a prefix pending
      send(8'hF0, 0);
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("mid_rst_outputs", {key_event, key_code, key_ext, key_break, paddle_l_up,
                                   timeout_err, overflow_err}, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (T + 4) @(negedge clk);
      check_eq("mid_rst_tmo", n_tmo_seen, m_tmo);
      check_eq("mid_rst_rx_wait", rx_wait, 1);

`ifdef PS2_KBD_PAUSE_EN
      send(8'h29, 0);
      check_eq("pause_on", pause_toggle, 1);
      send(8'h29, 0);
      check_eq("pause_repeat", pause_toggle, 1);
      send(8'hF0, 0); send(8'h29, 0);
      send(8'h29, 0);
      check_eq("pause_off", pause_toggle, 0);
`endif

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) b = 8'($urandom);
         else b = pick_tab[$urandom_range(0, 13)];
         case ($urandom_range(0, 6))
            0, 1:    idle = 0;
            2:       idle = 1;
            3:       idle = T - 1;
            4:       idle = T;
            default: idle = $urandom_range(0, 5);
         endcase
         send(b, idle);
         if ($urandom_range(0, 29) == 0) disable_pulse(1'($urandom_range(0, 1)));
      end
      flush();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
